comp_arbiter: RTL and testbench

COMP_ARBITER -- requirements
Module: comp_arbiter

---
 rtl/comp_arb_pkg.sv | 13 +
 rtl/Nbit_comp.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/comp_arbiter.sv | 147 ++++++++++++++
 tb/tb_comp_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/comp_arb_pkg.sv
// Shared types and defaults for the comparator arbiter.
package comp_arb_pkg;

   localparam int unsigned DefWidth = 16;
   localparam int unsigned DefNreq  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/Nbit_comp.sv
// Unsigned N-bit magnitude comparator; exactly one output is high.
module Nbit_comp #(
   parameter int unsigned N = 16
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic         gt_o,
   output logic         lt_o,
   output logic         eq_o
);

   assign gt_o = (a_i > b_i);
   assign lt_o = (a_i < b_i);
   assign eq_o = (a_i == b_i);

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first valid requester after last_i, wrapping at NREQ-1.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] valid_i,
   input  logic [IDW-1:0]  last_i,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [IDW-1:0] cand;

   // Walk from the farthest offset down so the nearest valid candidate wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int k = int'(NREQ); k > 0; k--) begin
         cand = IDW'((int'(last_i) + k) % int'(NREQ));
         if (valid_i[cand]) begin
            idx_o = cand;
            any_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one magnitude comparator among NREQ requesters.
// Optional COMP_ARB_COUNT_EN adds a saturating completed-transaction counter.
module comp_arbiter
   import comp_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned NREQ  = DefNreq
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*WIDTH-1:0]      req_a,
   input  logic [NREQ*WIDTH-1:0]      req_b,
   output logic [NREQ-1:0]            req_ready,
   output logic                       rsp_valid,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic                       rsp_gt,
   output logic                       rsp_lt,
   output logic                       rsp_eq,
   input  logic                       rsp_ready
`ifdef COMP_ARB_COUNT_EN
   ,output logic [15:0]               cmp_count
`endif
);

   localparam int unsigned IdW = $clog2(NREQ);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [IdW-1:0]   id_q, last_q;
   logic             valid_q, gt_q, lt_q, eq_q;

   logic [IdW-1:0]   pick_idx;
   logic             pick_any;
   logic             grant_en, cmp_en, hs_en;
   logic             cmp_gt, cmp_lt, cmp_eq;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IdW)
   ) u_rr_pick (
      .valid_i (req_valid),
      .last_i  (last_q),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   Nbit_comp #(
      .N (WIDTH)
   ) u_comp (
      .a_i  (a_q),
      .b_i  (b_q),
      .gt_o (cmp_gt),
      .lt_o (cmp_lt),
      .eq_o (cmp_eq)
   );

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      grant_en  = 1'b0;
      cmp_en    = 1'b0;
      hs_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               req_ready[pick_idx] = 1'b1;
               grant_en            = 1'b1;
               state_d             = CMP;
            end
         end
         CMP: begin
            cmp_en  = 1'b1;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               hs_en   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // The accept strobe must not leak out while reset is held.
      if (rst) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
         last_q  <= IdW'(NREQ - 1);
         valid_q <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         if (grant_en) begin
            a_q  <= req_a[pick_idx*WIDTH +: WIDTH];
            b_q  <= req_b[pick_idx*WIDTH +: WIDTH];
            id_q <= pick_idx;
         end
         if (cmp_en) begin
            gt_q    <= cmp_gt;
            lt_q    <= cmp_lt;
            eq_q    <= cmp_eq;
            valid_q <= 1'b1;
         end
         if (hs_en) begin
            last_q  <= id_q;
            valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid = valid_q;
   assign rsp_id    = id_q;
   assign rsp_gt    = gt_q;
   assign rsp_lt    = lt_q;
   assign rsp_eq    = eq_q;

`ifdef COMP_ARB_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (hs_en && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign cmp_count = count_q;
`endif

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed bench for comp_arbiter: vector table plus hand-written corner sequences.
module tb_comp_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic           rsp_gt, rsp_lt, rsp_eq;
   logic           rsp_ready;
`ifdef COMP_ARB_COUNT_EN
   logic [15:0]    cmp_count;
`endif

   comp_arbiter #(
      .WIDTH (W),
      .NREQ  (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_gt    (rsp_gt),
      .rsp_lt    (rsp_lt),
      .rsp_eq    (rsp_eq),
      .rsp_ready (rsp_ready)
`ifdef COMP_ARB_COUNT_EN
      ,.cmp_count (cmp_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] valid;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           id;
      logic         gt;
      logic         lt;
      logic         eq;
   } vec_t;

   vec_t vecs[8];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Chosen lane carries the operands; all other lanes carry zeros.
   task automatic drive_lanes(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = (i == id) ? a : '0;
         req_b[i*W +: W] = (i == id) ? b : '0;
      end
   endtask

   // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
   task automatic run_vec(input int k);
      vec_t v;
      logic [N-1:0] onehot;
      v = vecs[k];
      onehot = '0;
      onehot[v.id] = 1'b1;
      drive_lanes(v.id, v.a, v.b);
      req_valid = v.valid;
      rsp_ready = 1'b1;
      #1;
      check($sformatf("vec%0d ready", k), 32'(req_ready), 32'(onehot));
      @(posedge clk); #1;
      req_valid = '0;
      check($sformatf("vec%0d cmp_valid", k), 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("vec%0d valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("vec%0d id", k), 32'(rsp_id), 32'(v.id));
      check($sformatf("vec%0d flags", k), {29'd0, rsp_gt, rsp_lt, rsp_eq},
            {29'd0, v.gt, v.lt, v.eq});
      @(posedge clk); #1;
      check($sformatf("vec%0d drop", k), 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      vecs[0] = '{4'b0001, 16'h1234, 16'h1234, 0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{4'b1111, 16'hFFFF, 16'h0001, 1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'b1001, 16'h0005, 16'h0007, 3, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{4'b0110, 16'h8000, 16'h7FFF, 1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4'b0001, 16'h0000, 16'h0000, 0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{4'b0001, 16'h0001, 16'h0002, 0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{4'b1100, 16'hABCD, 16'hABCD, 2, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{4'b0011, 16'hFFFE, 16'hFFFF, 0, 1'b0, 1'b1, 1'b0};

      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      req_valid = 4'b1111;
      #1;
      check("rst ready", 32'(req_ready), 32'd0);
      check("rst valid", 32'(rsp_valid), 32'd0);
      check("rst id", 32'(rsp_id), 32'd0);
      check("rst flags", {29'd0, rsp_gt, rsp_lt, rsp_eq}, 32'd0);
      req_valid = '0;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int k = 0; k < 8; k++) run_vec(k);

      // All requesters held valid: grants rotate 0,1,2,3,0.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_a[i*W +: W] = 16'h0042;
         req_b[i*W +: W] = 16'h0042;
      end
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         logic [N-1:0] oh;
         oh = '0;
         oh[k % N] = 1'b1;
         check($sformatf("rr%0d ready", k), 32'(req_ready), 32'(oh));
         @(posedge clk); #1;
         check($sformatf("rr%0d cmp_ready", k), 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         check($sformatf("rr%0d id", k), 32'(rsp_id), 32'(k % N));
         check($sformatf("rr%0d eq", k), 32'(rsp_eq), 32'd1);
         @(posedge clk); #1;
      end
      req_valid = '0;

      // Backpressure with last_grant=0: valid 0011 grants 1, then 0 after handshake.
      drive_lanes(1, 16'hFFFF, 16'h0001);
      req_valid = 4'b0011;
      rsp_ready = 1'b0;
      #1;
      check("bp ready", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("bp valid", 32'(rsp_valid), 32'd1);
      check("bp id", 32'(rsp_id), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d hold", c), {28'd0, rsp_valid, rsp_gt, rsp_lt, rsp_eq},
               32'b1100);
         check($sformatf("bp%0d noready", c), 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp drop", 32'(rsp_valid), 32'd0);
      check("bp next ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); @(posedge clk); #1;

      // Operand change after accept must not disturb the result.
      drive_lanes(0, 16'h0002, 16'h0003);
      req_valid = 4'b0001;
      #1;
      check("op ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      req_a[W-1:0] = 16'h0009;
      @(posedge clk); #1;
      check("op flags", {28'd0, rsp_valid, rsp_gt, rsp_lt, rsp_eq}, 32'b1010);
      @(posedge clk); #1;

      // Reset while in RESP drops the response and restores requester 0 priority.
      drive_lanes(2, 16'h0010, 16'h0001);
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      check("mid valid", 32'(rsp_valid), 32'd1);
      rst = 1'b1;
      req_valid = 4'b1111;
      #1;
      check("mid async valid", 32'(rsp_valid), 32'd0);
      check("mid id", 32'(rsp_id), 32'd0);
      check("mid ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("mid next ready", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); @(posedge clk); #1;

`ifdef COMP_ARB_COUNT_EN
      rst = 1'b1;
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) run_vec(k);
      check("count3", 32'(cmp_count), 32'd3);
      rst = 1'b1;
      #1;
      check("count rst", 32'(cmp_count), 32'd0);
      rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
